// File: rtl/tug_game_ctrl.sv
// tug_game_ctrl -- controller for a two-player tug-of-war light game.
// Synchronizes and edge-detects the player buttons, forwards presses to the
// light field as registered L/R/CE strobes, detects points when a press would
// push the light past an end, keeps score and declares the winner.
// Optional build macro: TUG_CPU_PLAYER_EN replaces the right button with an
// LFSR-driven computer player whose press rate is set by cpuLevel.
// game_state is a debug view of the controller state (PLAY=0, POINT=1,
// HOLD=2, OVER=3).
module tug_game_ctrl #(
   parameter int HOLDOFF_CYCLES = 8,
   parameter int WIN_SCORE      = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       keyL,
   input  logic       keyR,
   input  logic       leftEnd,
   input  logic       rightEnd,
   input  logic [2:0] cpuLevel,
   output logic       L,
   output logic       R,
   output logic       CE,
   output logic       fieldReset,
   output logic [2:0] scoreL,
   output logic [2:0] scoreR,
   output logic       winL,
   output logic       winR,
   output logic [1:0] game_state
);

   // Hold counter just wide enough for HOLDOFF_CYCLES-1.
   localparam int          CW        = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);
   localparam logic [2:0]    WIN3      = 3'(WIN_SCORE);

   typedef enum logic [1:0] {PLAY, POINT, HOLD, OVER} state_t;

   state_t        state;
   logic [CW-1:0] hold_cnt;
   logic          start_pend;  // first cycle after reset: re-centre the field
   logic          left_won;    // winner of the point being scored

   logic l_s1, l_s2, l_prev;
   logic pulse_l, pulse_r;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   // Left button: two-flop synchronizer plus one flop for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_s1   <= 1'b0;
         l_s2   <= 1'b0;
         l_prev <= 1'b0;
      end else begin
         l_s1   <= keyL;
         l_s2   <= l_s1;
         l_prev <= l_s2;
      end
   end

   assign pulse_l = l_s2 & ~l_prev;

`ifdef TUG_CPU_PLAYER_EN
   logic [15:0] lfsr;
   logic        unused_keyr;

   // Free-running LFSR x^16+x^14+x^13+x^11+1 that drives the computer player.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Computer press: already synchronous, so it enters after the edge detector.
   assign pulse_r     = (lfsr[15:13] < cpuLevel) && (lfsr[12:0] == 13'd0);
   assign unused_keyr = keyR;
`else
   logic r_s1, r_s2, r_prev;
   logic unused_cpu;

   // Right button: two-flop synchronizer plus one flop for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= keyR;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign pulse_r    = r_s2 & ~r_prev;
   assign unused_cpu = ^cpuLevel;
`endif

   // Game FSM with registered field strobes, scores and win flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PLAY;
         hold_cnt   <= '0;
         start_pend <= 1'b1;
         left_won   <= 1'b0;
         scoreL     <= 3'd0;
         scoreR     <= 3'd0;
         winL       <= 1'b0;
         winR       <= 1'b0;
         L          <= 1'b0;
         R          <= 1'b0;
         CE         <= 1'b0;
         fieldReset <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         L          <= 1'b0;
         R          <= 1'b0;
         CE         <= 1'b0;
         fieldReset <= 1'b0;
         start_pend <= 1'b0;
         case (state)
            PLAY: begin
               if (start_pend) begin
                  fieldReset <= 1'b1;
               end else if (pulse_l && !pulse_r && leftEnd) begin
                  // Left pushed the light off its end: point, press not forwarded.
                  scoreL     <= sat_inc(scoreL);
                  left_won   <= 1'b1;
                  fieldReset <= 1'b1;
                  state      <= POINT;
               end else if (pulse_r && !pulse_l && rightEnd) begin
                  scoreR     <= sat_inc(scoreR);
                  left_won   <= 1'b0;
                  fieldReset <= 1'b1;
                  state      <= POINT;
               end else if (pulse_l || pulse_r) begin
                  // Simultaneous presses go out together and cancel in the field.
                  CE <= 1'b1;
                  L  <= pulse_l;
                  R  <= pulse_r;
               end
            end
            POINT: begin
               if (left_won ? (scoreL == WIN3) : (scoreR == WIN3)) begin
                  state <= OVER;
                  if (left_won) winL <= 1'b1;
                  else          winR <= 1'b1;
               end else begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            HOLD: begin
               // Dead time after a point; presses are dropped, not queued.
               if (hold_cnt == '0) state <= PLAY;
               else                hold_cnt <= hold_cnt - CW'(1);
            end
            OVER: begin
               // Game finished; only reset leaves this state.
            end
            default: state <= PLAY;
         endcase
      end
   end

   assign game_state = state;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Bench for tug_game_ctrl: directed button sequences, a rule-level model of
// the game checked every cycle, and literal checks at key moments.
module tb_tug_game_ctrl;

   localparam int HOLDOFF = 8;
   localparam int WIN     = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       keyL, keyR, leftEnd, rightEnd;
   logic [2:0] cpuLevel;
   logic       L, R, CE, fieldReset, winL, winR;
   logic [2:0] scoreL, scoreR;
   logic [1:0] game_state;

   int n_checks = 0;
   int n_fail   = 0;
   int ce_count;

   tug_game_ctrl #(.HOLDOFF_CYCLES(HOLDOFF), .WIN_SCORE(WIN)) dut (
      .clk(clk), .reset(reset), .keyL(keyL), .keyR(keyR),
      .leftEnd(leftEnd), .rightEnd(rightEnd), .cpuLevel(cpuLevel),
      .L(L), .R(R), .CE(CE), .fieldReset(fieldReset),
      .scoreL(scoreL), .scoreR(scoreR), .winL(winL), .winR(winR),
      .game_state(game_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- game model ----------------
   // Key samples from the last three edges: a press counts two edges after
   // the first edge that saw it high, and only if the edge before saw it low.
   int n_edge = 0;
   bit kl1, kl2, kl3, kr1, kr2, kr3;
   int skip = 0;
   bit over_next = 0;
   bit last_left = 0;
   int m_score_l = 0, m_score_r = 0;
   bit m_win_l = 0, m_win_r = 0;
   bit exp_l = 0, exp_r = 0, exp_ce = 0, exp_fr = 0;

   always @(posedge clk or posedge reset) begin
      bit pl, pr;
      if (reset) begin
         n_edge = 0;
         {kl1, kl2, kl3, kr1, kr2, kr3} = '0;
         skip = 0; over_next = 0; last_left = 0;
         m_score_l = 0; m_score_r = 0; m_win_l = 0; m_win_r = 0;
         {exp_l, exp_r, exp_ce, exp_fr} = '0;
      end else begin
         n_edge++;
         pl = kl2 && !kl3;
         pr = kr2 && !kr3;
         kl3 = kl2; kl2 = kl1; kl1 = keyL;
         kr3 = kr2; kr2 = kr1; kr1 = keyR;
         {exp_l, exp_r, exp_ce} = '0;
         exp_fr = (n_edge == 1);
         if (m_win_l || m_win_r) begin
            // game over: nothing moves
         end else if (over_next) begin
            over_next = 0;
            if (last_left) m_win_l = 1;
            else           m_win_r = 1;
         end else if (skip > 0) begin
            skip--;
         end else if (n_edge > 1 && (pl || pr)) begin
            if (pl && !pr && leftEnd) begin
               m_score_l = (m_score_l < 7) ? m_score_l + 1 : 7;
               last_left = 1;
               exp_fr = 1;
               if (m_score_l == WIN) over_next = 1;
               else                  skip = 1 + HOLDOFF;
            end else if (pr && !pl && rightEnd) begin
               m_score_r = (m_score_r < 7) ? m_score_r + 1 : 7;
               last_left = 0;
               exp_fr = 1;
               if (m_score_r == WIN) over_next = 1;
               else                  skip = 1 + HOLDOFF;
            end else begin
               exp_ce = 1; exp_l = pl; exp_r = pr;
            end
         end
      end
   end

   // Every-cycle comparison of all game outputs against the model.
   always @(posedge clk) begin
      #2;
      check("cycle_outputs",
            {L, R, CE, fieldReset, scoreL, scoreR, winL, winR},
            {exp_l, exp_r, exp_ce, exp_fr, 3'(m_score_l), 3'(m_score_r), m_win_l, m_win_r});
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_outputs", {L, R, CE, fieldReset, winL, winR}, 6'b0);
      check("rst_async_scores", {scoreL, scoreR}, 6'b0);
      repeat (3) cyc();
      reset = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      keyL = 0; keyR = 0; leftEnd = 0; rightEnd = 0; cpuLevel = 3'd7;
      repeat (3) cyc();
      reset = 1'b0;

      // Field re-centre right after reset, then 3-cycle press latency.
      cyc();
      check("fr_after_reset", fieldReset, 1);
      check("ce_edge1", CE, 0);
      repeat (3) cyc();
      keyL = 1;
      cyc(); cyc();
      check("ce_edge6", CE, 0);
      cyc();
      check("ce_edge7", CE, 1);
      check("l_edge7", L, 1);
      check("r_edge7", R, 0);

      // Held key yields a single press; release and repress yields another.
      ce_count = 0;
      repeat (19) begin cyc(); ce_count += CE; end
      check("held_key_single_ce", ce_count, 0);
      keyL = 0;
      repeat (3) cyc();
      keyL = 1;
      ce_count = 0;
      repeat (4) begin cyc(); ce_count += CE; end
      check("repress_ce", ce_count, 1);
      keyL = 0;
      repeat (4) cyc();

      // Simultaneous presses at both ends: forwarded, never a point.
      leftEnd = 1; rightEnd = 1; keyL = 1; keyR = 1;
      repeat (3) cyc();
      check("both_lrce", {L, R, CE}, 3'b111);
      check("both_no_score", {scoreL, scoreR, fieldReset}, 7'b0);
      cyc();
      check("both_one_cycle", CE, 0);
      keyL = 0; keyR = 0; rightEnd = 0;
      repeat (3) cyc();

      // Right press while only the left end is lit: an ordinary move.
      keyR = 1;
      repeat (3) cyc();
      check("r_move", {L, R, CE}, 3'b011);
      check("r_move_score", scoreR, 0);
      keyR = 0;
      repeat (3) cyc();

      // Left point, presses during the dead time dropped, later press moves.
      keyL = 1;
      repeat (3) cyc();
      check("lpoint_ce", CE, 0);
      check("lpoint_fr", fieldReset, 1);
      check("lpoint_score", scoreL, 1);
      keyL = 0;
      ce_count = 0;
      cyc(); ce_count += CE;
      check("lpoint_fr_one_cycle", fieldReset, 0);
      keyL = 1;
      repeat (8) begin cyc(); ce_count += CE; end
      check("hold_drops_presses", ce_count, 0);
      keyL = 0; leftEnd = 0;
      cyc();
      keyL = 1;
      repeat (3) cyc();
      check("after_hold_ce", {L, R, CE}, 3'b101);
      keyL = 0;
      repeat (3) cyc();

      // Right point; press on last dead edge dropped, press on first live edge taken.
      rightEnd = 1; keyR = 1;
      repeat (3) cyc();
      check("rpoint_score", scoreR, 1);
      check("rpoint_fr_noce", {fieldReset, CE}, 2'b10);
      keyR = 0; rightEnd = 0;
      ce_count = 0;
      repeat (6) begin cyc(); ce_count += CE; end
      keyR = 1;
      cyc(); ce_count += CE;
      keyL = 1;
      cyc(); ce_count += CE;
      cyc(); ce_count += CE;
      check("last_dead_edge_dropped", ce_count, 0);
      cyc();
      check("first_live_edge", {L, R, CE}, 3'b101);
      keyL = 0; keyR = 0;
      repeat (3) cyc();

      // Second left point wins the game.
      leftEnd = 1; keyL = 1;
      repeat (3) cyc();
      check("win_point_score", scoreL, WIN);
      check("win_point_fr", fieldReset, 1);
      cyc();
      check("win_flags", {winL, winR}, 2'b10);
      keyL = 0; leftEnd = 0;
      cyc();
      keyL = 1;
      ce_count = 0;
      repeat (6) begin cyc(); ce_count += CE + fieldReset; end
      check("over_no_strobes", ce_count, 0);
      check("over_win_held", winL, 1);
      keyL = 0;

      // Reset during OVER.
      do_reset();
      cyc();
      check("fr_after_reset2", fieldReset, 1);
      check("scores_after_reset2", {scoreL, scoreR, winL, winR}, 8'b0);
      repeat (2) cyc();

      // Reset during HOLD.
      leftEnd = 1; keyL = 1;
      repeat (3) cyc();
      check("pt_before_hold_reset", scoreL, 1);
      keyL = 0;
      repeat (3) cyc();
      do_reset();
      cyc();
      check("fr_after_reset3", fieldReset, 1);
      check("score_after_reset3", scoreL, 0);
      leftEnd = 0; keyL = 1;
      repeat (3) cyc();
      check("play_after_hold_reset", {L, R, CE}, 3'b101);
      keyL = 0;
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
